comparador_izq_der: RTL and testbench
=====================================

// Module: comparador_izq_der
// PURPOSE
//  Sequential bit-serial magnitude comparator scanning MSB->LSB (izquierda->derecha),
//  one bit per clock; counterpart to the LSB-first serial comparator path.
//  Latches two N-bit words on a start strobe, reports mayor/igual/menor with a done pulse.
//  Sits between operand registers and control logic needing a registered comparison result.
// PARAMETERS
//  N                4  operand width in bits (>=2)
//  SALIDA_TEMPRANA  1  1: finish at first differing bit; 0: always scan all N bits (fixed latency)
// PORTS
//  clk       in   1  single clock, rising edge
//  rst_n     in   1  asynchronous active-low reset
//  inicio    in   1  start strobe, sampled only when ocupado=0
//  palabraA  in   N  operand A, captured on accepted inicio
//  palabraB  in   N  operand B, captured on accepted inicio
//  ocupado   out  1  high while a comparison is in progress
//  listo     out  1  one-cycle pulse: result valid/updated this cycle
//  mayor     out  1  A > B (unsigned), held until next result
//  igual     out  1  A == B, held until next result
//  menor     out  1  A < B, held until next result
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=REPOSO, ocupado=0, listo=0, mayor=0, igual=0, menor=0,
//    operand regs=0, idx=0. Flags all 0 means "no result yet".
//  - States: REPOSO -> BARRIDO -> FIN -> REPOSO.
//    REPOSO: edge with inicio=1 -> capture A,B; idx<=N-1; ocupado<=1; go BARRIDO (edge E0).
//    BARRIDO: each edge Ek (k=1..N) compares A[idx] vs B[idx] via comparador_bit.
//      A[idx]!=B[idx] and SALIDA_TEMPRANA=1 -> decide (mayor if A bit=1 else menor), go FIN.
//      SALIDA_TEMPRANA=0 -> record first difference in a sticky decided/sense reg, keep scanning.
//      idx==0 -> decide (recorded difference, else igual), go FIN; otherwise idx<=idx-1.
//    FIN: transient; decision edge already registers flags, listo<=1, ocupado<=0, state<=REPOSO.
//      (Implementation may fold FIN into the decision edge; observable timing below is normative.)
//  - Timing: listo=1 exactly one cycle, following edge Ek, k = bits examined
//    (early: N - index of first differing bit; equal or SALIDA_TEMPRANA=0: k=N).
//    ocupado high from E0 through Ek-1 inclusive, low in the listo cycle.
//  - Exactly one of mayor/igual/menor is high after the first result; all three update at the
//    same edge as listo; values hold until the next decision edge.
//  - inicio while ocupado=1: ignored, no recapture, no effect on current scan.
//  - inicio in the listo cycle (ocupado=0): accepted; back-to-back ops allowed, min period k+1.
//  - Operand inputs change during scan: no effect (captured copies used).
//  - rst_n low mid-scan: immediate abort to reset values; no listo for the aborted op.
//  - idx counter width $clog2(N); never decrements below 0 (no wrap).
// STRUCTURE
//  - Package comparador_pkg: state encoding localparams (REPOSO, BARRIDO, FIN), result
//    encoding (RES_MENOR=2'b00, RES_IGUAL=2'b01, RES_MAYOR=2'b10).
//  - Sub-module comparador_bit: combinational 1-bit cell, inputs a,b -> gt, eq, lt.
//  - Top: FSM, idx down-counter, operand regs, sticky decision reg, output regs.
// TESTING
//  1) N=4, early: A=5,B=8 -> bit3 differs, listo at E1, menor=1, mayor=igual=0.
//  2) N=4, early: A=12,B=7 -> listo at E1, mayor=1; then A=6,B=6 -> listo at E4, igual=1.
//  3) N=4, SALIDA_TEMPRANA=0: A=5,B=8 -> listo at E4 (not E1), menor=1; ocupado 4 cycles.
//  4) Start A=3,B=2, pulse inicio with A=0,B=9 at E2 -> ignored; result mayor=1 at E4.
//  5) A=6,B=6 started, rst_n=0 after E2 -> all outputs 0 immediately, no listo;
//     after release, A=9,B=4 -> mayor=1 at E1.
//  6) N=8: A=255,B=254 -> listo at E8, mayor=1; inicio in listo cycle with A=0,B=0 -> igual at E8.

Source files
------------

// File: rtl/comparador_pkg.sv
// rtl/comparador_pkg.sv - shared encodings for the MSB-first serial magnitude comparator
package comparador_pkg;

    // FSM state encoding
    localparam logic [1:0] REPOSO  = 2'd0;
    localparam logic [1:0] BARRIDO = 2'd1;
    localparam logic [1:0] FIN     = 2'd2;

    // Result encoding
    localparam logic [1:0] RES_MENOR = 2'b00;
    localparam logic [1:0] RES_IGUAL = 2'b01;
    localparam logic [1:0] RES_MAYOR = 2'b10;

    // Map the sense of a differing bit (1: A bit is the set one) to a result code
    function automatic logic [1:0] resultado_de_sentido(input logic sentido_mayor);
        return sentido_mayor ? RES_MAYOR : RES_MENOR;
    endfunction

endpackage

// File: rtl/comparador_bit.sv
// rtl/comparador_bit.sv - combinational 1-bit magnitude cell
module comparador_bit (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic eq,
    output logic lt
);

    assign gt = a & ~b;
    assign eq = ~(a ^ b);
    assign lt = ~a & b;

endmodule

// File: rtl/comparador_izq_der.sv
// rtl/comparador_izq_der.sv - bit-serial MSB-first unsigned magnitude comparator
module comparador_izq_der
    import comparador_pkg::*;
#(
    parameter int N               = 4,
    parameter bit SALIDA_TEMPRANA = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inicio,
    input  logic [N-1:0] palabraA,
    input  logic [N-1:0] palabraB,
    output logic         ocupado,
    output logic         listo,
    output logic         mayor,
    output logic         igual,
    output logic         menor
);

    localparam int             IW      = $clog2(N);
    localparam logic [IW-1:0]  IDX_MAX = IW'(N - 1);
    localparam logic [IW-1:0]  IDX_UNO = IW'(1);

    logic [1:0]    r_estado;
    logic [1:0]    w_estado_sig;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [IW-1:0] r_idx;
    logic          r_dec;
    logic          r_sentido;
    logic          r_listo;
    logic          r_ocupado;
    logic          r_mayor;
    logic          r_igual;
    logic          r_menor;

    logic          w_bit_gt;
    logic          w_bit_eq;
    logic          w_bit_lt;
    logic          w_dif;
    logic          w_corte;
    logic          w_captura;
    logic          w_decide;
    logic          w_sentido;
    logic          w_hay_dif;
    logic [1:0]    w_res;

    comparador_bit u_bit (
        .a  (r_a[r_idx]),
        .b  (r_b[r_idx]),
        .gt (w_bit_gt),
        .eq (w_bit_eq),
        .lt (w_bit_lt)
    );

    assign w_dif = w_bit_gt | w_bit_lt;

    // Scan ends on the current bit: early exit on a difference, or the LSB reached
    assign w_corte = (r_estado == BARRIDO) &&
                     ((SALIDA_TEMPRANA && w_dif) || (r_idx == '0));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= REPOSO;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Next-state logic; FIN is folded into the decision edge, so BARRIDO returns straight to REPOSO
    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            REPOSO:  if (inicio)  w_estado_sig = BARRIDO;
            BARRIDO: if (w_corte) w_estado_sig = REPOSO;
            FIN:                  w_estado_sig = REPOSO;
            default:              w_estado_sig = REPOSO;
        endcase
    end

    // Output/control decode: capture strobe, decision strobe and the result to register
    always_comb begin
        w_captura = (r_estado == REPOSO) && inicio;
        w_decide  = w_corte;
        // A difference already recorded outranks the current bit (it was more significant)
        w_sentido = r_dec ? r_sentido : w_bit_gt;
        w_hay_dif = r_dec | ~w_bit_eq;
        w_res     = w_hay_dif ? resultado_de_sentido(w_sentido) : RES_IGUAL;
    end

    // Operand copies, index down-counter and sticky first-difference record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_dec     <= 1'b0;
            r_sentido <= 1'b0;
        end else if (w_captura) begin
            r_a       <= palabraA;
            r_b       <= palabraB;
            r_idx     <= IDX_MAX;
            r_dec     <= 1'b0;
            r_sentido <= 1'b0;
        end else if (r_estado == BARRIDO) begin
            if (!r_dec && w_dif) begin
                r_dec     <= 1'b1;
                r_sentido <= w_bit_gt;
            end
            if (!w_corte) begin
                r_idx <= r_idx - IDX_UNO;
            end
        end
    end

    // Registered handshake and result flags; flags hold between decisions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_listo   <= 1'b0;
            r_ocupado <= 1'b0;
            r_mayor   <= 1'b0;
            r_igual   <= 1'b0;
            r_menor   <= 1'b0;
        end else begin
            r_listo <= w_decide;
            if (w_captura) begin
                r_ocupado <= 1'b1;
            end else if (w_decide) begin
                r_ocupado <= 1'b0;
            end
            if (w_decide) begin
                r_mayor <= (w_res == RES_MAYOR);
                r_igual <= (w_res == RES_IGUAL);
                r_menor <= (w_res == RES_MENOR);
            end
        end
    end

    assign ocupado = r_ocupado;
    assign listo   = r_listo;
    assign mayor   = r_mayor;
    assign igual   = r_igual;
    assign menor   = r_menor;

endmodule

// File: tb/tb_comparador_izq_der.sv
// tb/tb_comparador_izq_der.sv - directed self-checking bench for comparador_izq_der
module tb_comparador_izq_der;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       ini0, ini1, ini2;
    logic [3:0] a0, b0, a1, b1;
    logic [7:0] a2, b2;
    logic       oc0, li0, ma0, ig0, me0;
    logic       oc1, li1, ma1, ig1, me1;
    logic       oc2, li2, ma2, ig2, me2;

    int errores = 0;
    int total   = 0;

    comparador_izq_der #(.N(4), .SALIDA_TEMPRANA(1'b1)) dut_temprana (
        .clk(clk), .rst_n(rst_n), .inicio(ini0), .palabraA(a0), .palabraB(b0),
        .ocupado(oc0), .listo(li0), .mayor(ma0), .igual(ig0), .menor(me0)
    );

    comparador_izq_der #(.N(4), .SALIDA_TEMPRANA(1'b0)) dut_fija (
        .clk(clk), .rst_n(rst_n), .inicio(ini1), .palabraA(a1), .palabraB(b1),
        .ocupado(oc1), .listo(li1), .mayor(ma1), .igual(ig1), .menor(me1)
    );

    comparador_izq_der #(.N(8), .SALIDA_TEMPRANA(1'b1)) dut_ancho (
        .clk(clk), .rst_n(rst_n), .inicio(ini2), .palabraA(a2), .palabraB(b2),
        .ocupado(oc2), .listo(li2), .mayor(ma2), .igual(ig2), .menor(me2)
    );

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            errores++;
            $display("FAIL %s: obtenido=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    // {ocupado, listo, mayor, igual, menor}
    function automatic logic [4:0] leer(input int d);
        case (d)
            0:       return {oc0, li0, ma0, ig0, me0};
            1:       return {oc1, li1, ma1, ig1, me1};
            default: return {oc2, li2, ma2, ig2, me2};
        endcase
    endfunction

    task automatic ciclo;
        @(posedge clk);
        #1;
    endtask

    // Drive inicio for one edge (E0) with the given operands
    task automatic arrancar(input int d, input logic [7:0] va, input logic [7:0] vb);
        case (d)
            0:       begin ini0 = 1'b1; a0 = va[3:0]; b0 = vb[3:0]; end
            1:       begin ini1 = 1'b1; a1 = va[3:0]; b1 = vb[3:0]; end
            default: begin ini2 = 1'b1; a2 = va;      b2 = vb;      end
        endcase
        ciclo();
        ini0 = 1'b0;
        ini1 = 1'b0;
        ini2 = 1'b0;
    endtask

    // Count edges until listo; leaves the bench in the listo cycle
    task automatic esperar(input string tag, input int d, input int k0,
                           input int k_esp, input logic [2:0] f_esp);
        int         k;
        int         occ;
        logic [4:0] s;
        logic       visto;
        k     = k0;
        occ   = k0;
        visto = 1'b0;
        s     = leer(d);
        while (k < 40 && !visto) begin
            s = leer(d);
            if (s[4]) occ++;
            ciclo();
            k++;
            s     = leer(d);
            visto = s[3];
        end
        chequear({tag, " listo"}, {31'd0, visto}, 32'd1);
        chequear({tag, " latencia"}, k, k_esp);
        chequear({tag, " flags"}, {29'd0, s[2:0]}, {29'd0, f_esp});
        chequear({tag, " ocupado_en_listo"}, {31'd0, s[4]}, 32'd0);
        chequear({tag, " ciclos_ocupado"}, occ, k_esp);
    endtask

    initial begin
        logic [4:0] s;
        logic       algun_listo;
        rst_n = 1'b0;
        ini0 = 1'b0; ini1 = 1'b0; ini2 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        repeat (2) ciclo();
        chequear("reset temprana", {27'd0, leer(0)}, 32'd0);
        chequear("reset fija",     {27'd0, leer(1)}, 32'd0);
        chequear("reset ancho",    {27'd0, leer(2)}, 32'd0);
        rst_n = 1'b1;
        ciclo();

        // 5 < 8, bit3 differs
        arrancar(0, 8'd5, 8'd8);
        esperar("t1 5v8", 0, 0, 1, 3'b001);
        ciclo();
        s = leer(0);
        chequear("t1 pulso_unico", {31'd0, s[3]}, 32'd0);
        chequear("t1 retiene", {29'd0, s[2:0]}, 32'b001);

        // 12 > 7 then back-to-back 6 == 6
        arrancar(0, 8'd12, 8'd7);
        esperar("t2 12v7", 0, 0, 1, 3'b100);
        arrancar(0, 8'd6, 8'd6);
        esperar("t2 6v6", 0, 0, 4, 3'b010);
        arrancar(0, 8'd2, 8'd0);
        esperar("t2 2v0", 0, 0, 3, 3'b100);
        arrancar(0, 8'd4, 8'd5);
        esperar("t2 4v5", 0, 0, 4, 3'b001);

        // Fixed latency mode
        arrancar(1, 8'd5, 8'd8);
        esperar("t3 5v8", 1, 0, 4, 3'b001);
        arrancar(1, 8'd12, 8'd7);
        esperar("t3 12v7", 1, 0, 4, 3'b100);
        arrancar(1, 8'd6, 8'd6);
        esperar("t3 6v6", 1, 0, 4, 3'b010);

        // inicio while busy must be ignored
        ciclo();
        arrancar(0, 8'd3, 8'd2);
        ciclo();
        s = leer(0);
        chequear("t4 ocupado_e1", {31'd0, s[4]}, 32'd1);
        ini0 = 1'b1; a0 = 4'd0; b0 = 4'd9;
        ciclo();
        ini0 = 1'b0;
        s = leer(0);
        chequear("t4 ocupado_e2", {31'd0, s[4]}, 32'd1);
        esperar("t4 3v2", 0, 2, 4, 3'b100);

        // Async reset mid-scan
        ciclo();
        arrancar(0, 8'd6, 8'd6);
        ciclo();
        ciclo();
        rst_n = 1'b0;
        #1;
        s = leer(0);
        chequear("t5 reset_inmediato", {27'd0, s}, 32'd0);
        algun_listo = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ciclo();
            s = leer(0);
            algun_listo = algun_listo | s[3];
        end
        chequear("t5 sin_listo", {31'd0, algun_listo}, 32'd0);
        rst_n = 1'b1;
        ciclo();
        s = leer(0);
        chequear("t5 tras_reset", {27'd0, s}, 32'd0);
        arrancar(0, 8'd9, 8'd4);
        esperar("t5 9v4", 0, 0, 1, 3'b100);

        // N=8, back-to-back start in the listo cycle
        arrancar(2, 8'd255, 8'd254);
        esperar("t6 255v254", 2, 0, 8, 3'b100);
        arrancar(2, 8'd0, 8'd0);
        esperar("t6 0v0", 2, 0, 8, 3'b010);
        ciclo();
        s = leer(2);
        chequear("t6 pulso_unico", {31'd0, s[3]}, 32'd0);
        chequear("t6 retiene", {29'd0, s[2:0]}, 32'b010);

        $display("Result: errors=%0d of %0d checks", errores, total);
        $finish;
    end

endmodule
